// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and helpers for the multi-channel UART transmitter
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  // Width needed to index n items, never below one bit so single-entry cases still get a vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1/8N2 frame generator with baud counter
module uart_tx_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] data,
  output logic              SDO,
  output logic              idle,
  output logic              ready
);

  localparam int CNT_W = clog2(BAUD_DIV);

  uartState_t        state, stateNext;
  logic [CNT_W-1:0]  baudCnt;
  logic [2:0]        bitIdx;
  logic [BYTE_W-1:0] dataReg;
  logic              baudDone, lastData, stopDone;

  assign baudDone = baudCnt == CNT_W'(BAUD_DIV - 1);
  assign lastData = baudDone && (bitIdx == 3'd7);
  assign stopDone = baudDone && (bitIdx == 3'(STOP_BITS - 1));
  // A new byte is taken either from IDLE or on the final stop cycle, giving gapless frames.
  assign ready    = (state == IDLE) || ((state == STOP) && stopDone);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)    stateNext = START;
      START:   if (baudDone) stateNext = DATA;
      DATA:    if (lastData) stateNext = STOP;
      STOP:    if (stopDone) stateNext = start ? START : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    SDO  = 1'b1;
    idle = (state == IDLE);
    case (state)
      START:   SDO = 1'b0;
      DATA:    SDO = dataReg[bitIdx];
      default: SDO = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      baudCnt <= '0;
      bitIdx  <= '0;
      dataReg <= '0;
    end else begin
      baudCnt <= ((state == IDLE) || baudDone) ? '0 : baudCnt + 1'b1;
      if (stateNext != state) bitIdx <= '0;
      else if (baudDone)      bitIdx <= bitIdx + 3'd1;
      if (ready && start) dataReg <= data;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - arbitrates NUM_CH byte requesters into a shared FIFO feeding a UART transmitter
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 434,
  parameter int STOP_BITS  = 1,
  parameter int RR_MODE    = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [BYTE_W*NUM_CH-1:0] Data,
  input  logic [NUM_CH-1:0]        RequestToSend,
  output logic [NUM_CH-1:0]        DataReceivedOut,
  output logic                     FifoFull,
  output logic                     Busy,
  output logic                     SDO
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = clog2(NUM_CH);

  logic [BYTE_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;
  logic [CH_W-1:0]   rrPtr, grantIdx;
  logic [NUM_CH-1:0] eligible;
  logic              grantValid, push, pop, serReady, serIdle;

  // Masking with the ack stops a still-held request from being taken twice.
  assign eligible = RequestToSend & ~DataReceivedOut;
  assign FifoFull = count == CNT_W'(FIFO_DEPTH);
  assign push     = grantValid && !FifoFull;
  assign pop      = (count != '0) && serReady;
  assign Busy     = (count != '0) || !serIdle;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (eligible[i]) begin
          grantValid = 1'b1;
          grantIdx   = CH_W'(i);
        end
      end
    end else begin
      // Walk backwards so the channel nearest rrPtr is the last, and winning, assignment.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (eligible[(int'(rrPtr) + k) % NUM_CH]) begin
          grantValid = 1'b1;
          grantIdx   = CH_W'((int'(rrPtr) + k) % NUM_CH);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifoMem[wrPtr] <= Data[grantIdx*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr           <= '0;
      rdPtr           <= '0;
      count           <= '0;
      rrPtr           <= '0;
      DataReceivedOut <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (push && (RR_MODE != 0))
        rrPtr <= (grantIdx == CH_W'(NUM_CH - 1)) ? '0 : grantIdx + 1'b1;
      DataReceivedOut <= push ? (NUM_CH'(1) << grantIdx) : '0;
    end
  end

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV),
    .STOP_BITS(STOP_BITS)
  ) u_serializer (
    .Clock(Clock),
    .Reset(Reset),
    .start(pop),
    .data (fifoMem[rdPtr]),
    .SDO  (SDO),
    .idle (serIdle),
    .ready(serReady)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (fixed-priority 8N1 and round-robin 8N2 instances)
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int BAUD = 4;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic        Reset0, Reset1;
  logic [15:0] Data0, Data1;
  logic [1:0]  Req0, Req1, Ack0, Ack1;
  logic        Full0, Full1, Busy0, Busy1, Sdo0, Sdo1;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int         start0[$];

  uart_tx_arbiter #(.NUM_CH(2), .FIFO_DEPTH(4), .BAUD_DIV(BAUD), .STOP_BITS(1), .RR_MODE(0)) dut0 (
    .Clock(Clock), .Reset(Reset0), .Data(Data0), .RequestToSend(Req0),
    .DataReceivedOut(Ack0), .FifoFull(Full0), .Busy(Busy0), .SDO(Sdo0));

  uart_tx_arbiter #(.NUM_CH(2), .FIFO_DEPTH(4), .BAUD_DIV(BAUD), .STOP_BITS(2), .RR_MODE(1)) dut1 (
    .Clock(Clock), .Reset(Reset1), .Data(Data1), .RequestToSend(Req1),
    .DataReceivedOut(Ack1), .FifoFull(Full1), .Busy(Busy1), .SDO(Sdo1));

  typedef struct {
    bit         active;
    int         cnt;
    logic [7:0] data;
    bit         bad;
  } rx_t;

  rx_t        rx0, rx1;
  bit         done0, began0, done1, began1;
  logic [7:0] exp0, exp1;

  task automatic rxStep(input logic sdo, input int stopBits, inout rx_t st, output bit done, output bit began);
    done  = 1'b0;
    began = 1'b0;
    if (!st.active) begin
      if (sdo === 1'b0) begin
        st.active = 1'b1;
        st.cnt    = 0;
        st.bad    = 1'b0;
        began     = 1'b1;
      end
    end else begin
      st.cnt++;
      if (st.cnt == BAUD / 2 && sdo !== 1'b0) st.bad = 1'b1;
      if (st.cnt >= BAUD && st.cnt < 9 * BAUD && (st.cnt % BAUD) == BAUD / 2)
        st.data[st.cnt / BAUD - 1] = sdo;
      if (st.cnt >= 9 * BAUD && (st.cnt % BAUD) == BAUD / 2 && sdo !== 1'b1) st.bad = 1'b1;
      if (st.cnt == (9 + stopBits) * BAUD - 1) begin
        st.active = 1'b0;
        done      = 1'b1;
      end
    end
  endtask

  always @(negedge Clock) begin
    if (Reset0 !== 1'b0) rx0.active = 1'b0;
    else begin
      rxStep(Sdo0, 1, rx0, done0, began0);
      if (began0) start0.push_back(cyc);
      if (done0) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL dut0_frame: got %h, no byte expected", rx0.data);
        end else begin
          exp0 = sb0.pop_front();
          if (rx0.data !== exp0 || rx0.bad) begin
            errors++;
            $display("FAIL dut0_frame: got %h framing_bad=%0d, want %h", rx0.data, rx0.bad, exp0);
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    if (Reset1 !== 1'b0) rx1.active = 1'b0;
    else begin
      rxStep(Sdo1, 2, rx1, done1, began1);
      if (done1) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL dut1_frame: got %h, no byte expected", rx1.data);
        end else begin
          exp1 = sb1.pop_front();
          if (rx1.data !== exp1 || rx1.bad) begin
            errors++;
            $display("FAIL dut1_frame: got %h framing_bad=%0d, want %h", rx1.data, rx1.bad, exp1);
          end
        end
      end
    end
  end

  task automatic waitIdle(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge Clock);
      if (which == 0) ok = (sb0.size() == 0) && (Busy0 === 1'b0);
      else            ok = (sb1.size() == 0) && (Busy1 === 1'b0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_dut%0d: queue=%0d busy=%b, want empty and idle", which,
               which == 0 ? sb0.size() : sb1.size(), which == 0 ? Busy0 : Busy1);
    end
  endtask

  task automatic test_reset();
    Reset0 = 1'b1; Reset1 = 1'b1;
    Req0 = '0; Req1 = '0; Data0 = '0; Data1 = '0;
    repeat (3) @(negedge Clock);
    checks++;
    if (Sdo0 !== 1'b1 || Ack0 !== 2'b00 || Full0 !== 1'b0 || Busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0: SDO=%b ack=%b full=%b busy=%b, want 1 00 0 0", Sdo0, Ack0, Full0, Busy0);
    end
    checks++;
    if (Sdo1 !== 1'b1 || Ack1 !== 2'b00 || Full1 !== 1'b0 || Busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1: SDO=%b ack=%b full=%b busy=%b, want 1 00 0 0", Sdo1, Ack1, Full1, Busy1);
    end
    Reset0 = 1'b0; Reset1 = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_single_frame();
    logic [7:0] v;
    logic       expSdo, expBusy;
    logic [1:0] expAck;
    v = 8'hA5;
    @(negedge Clock);
    Data0[7:0] = v;
    Req0 = 2'b01;
    for (int c = 0; c < 46; c++) begin
      if (c > 0) @(negedge Clock);
      expSdo  = (c >= 2 && c <= 5) ? 1'b0 : (c >= 6 && c <= 37) ? v[(c - 6) / BAUD] : 1'b1;
      expBusy = (c >= 1 && c <= 41);
      expAck  = (c == 1) ? 2'b01 : 2'b00;
      checks++;
      if (Sdo0 !== expSdo || Busy0 !== expBusy || Ack0 !== expAck) begin
        errors++;
        $display("FAIL single_frame c%0d: SDO=%b busy=%b ack=%b, want %b %b %b",
                 c, Sdo0, Busy0, Ack0, expSdo, expBusy, expAck);
      end
      if (c == 1) begin
        sb0.push_back(v);
        Req0 = 2'b00;
      end
    end
    waitIdle(0);
  endtask

  task automatic test_priority();
    int base;
    @(negedge Clock);
    base  = start0.size();
    Data0 = {8'h55, 8'h0F};
    Req0  = 2'b11;
    @(negedge Clock);
    checks++;
    if (Ack0 !== 2'b10) begin
      errors++;
      $display("FAIL priority_ack1: ack=%b, want 10", Ack0);
    end
    sb0.push_back(8'h55);
    Req0[1] = 1'b0;
    @(negedge Clock);
    checks++;
    if (Ack0 !== 2'b01) begin
      errors++;
      $display("FAIL priority_ack2: ack=%b, want 01", Ack0);
    end
    sb0.push_back(8'h0F);
    Req0[0] = 1'b0;
    waitIdle(0);
    checks++;
    if (start0.size() - base != 2) begin
      errors++;
      $display("FAIL back_to_back_count: frames=%0d, want 2", start0.size() - base);
    end else if (start0[base + 1] - start0[base] != 10 * BAUD) begin
      errors++;
      $display("FAIL back_to_back_gap: start spacing=%0d, want %0d", start0[base + 1] - start0[base], 10 * BAUD);
    end
  endtask

  task automatic test_fifo_full();
    int n, c5, c6;
    n = 0; c5 = -1; c6 = -1;
    @(negedge Clock);
    Data0[7:0] = 8'h01;
    Req0 = 2'b01;
    for (int c = 1; c < 300 && n < 6; c++) begin
      @(negedge Clock);
      if (Ack0[0]) begin
        n++;
        sb0.push_back(Data0[7:0]);
        if (n == 4 || n == 5) begin
          checks++;
          if (Full0 !== (n == 5)) begin
            errors++;
            $display("FAIL fifo_full_after_%0d: full=%b, want %b", n, Full0, n == 5);
          end
        end
        if (n == 5) c5 = c;
        if (n == 6) c6 = c;
        if (n < 6) Data0[7:0] = 8'(n + 1);
        else       Req0 = 2'b00;
      end
    end
    Req0 = 2'b00;
    checks++;
    if (c6 - c5 != 34) begin
      errors++;
      $display("FAIL fifo_full_stall: 6th ack %0d cycles after 5th (accepts=%0d), want 34", c6 - c5, n);
    end
    waitIdle(0);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] vals [3];
    vals[0] = 8'hC3; vals[1] = 8'h11; vals[2] = 8'h22;
    n = 0;
    @(negedge Clock);
    Data0[7:0] = vals[0];
    Req0 = 2'b01;
    for (int c = 1; c < 50 && n < 3; c++) begin
      @(negedge Clock);
      if (Ack0[0]) begin
        sb0.push_back(vals[n]);
        n++;
        if (n < 3) Data0[7:0] = vals[n];
      end
    end
    Req0 = 2'b00;
    repeat (9) @(negedge Clock);
    Reset0 = 1'b1;
    sb0.delete();
    @(negedge Clock);
    checks++;
    if (Sdo0 !== 1'b1 || Full0 !== 1'b0 || Busy0 !== 1'b0 || Ack0 !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid: SDO=%b full=%b busy=%b ack=%b, want 1 0 0 00", Sdo0, Full0, Busy0, Ack0);
    end
    @(negedge Clock);
    Reset0 = 1'b0;
    @(negedge Clock);
    Data0[7:0] = 8'h3C;
    Req0 = 2'b01;
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge Clock);
      if (Ack0[0]) n = 1;
    end
    Req0 = 2'b00;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL reset_mid_accept: ack seen=%0d, want 1", n);
    end else sb0.push_back(8'h3C);
    waitIdle(0);
  endtask

  task automatic test_round_robin();
    int n, expCh, ch;
    n = 0; expCh = 0;
    @(negedge Clock);
    Data1 = {8'h20, 8'h10};
    Req1  = 2'b11;
    for (int c = 1; c < 600 && n < 6; c++) begin
      @(negedge Clock);
      if (Ack1 !== 2'b00) begin
        checks++;
        if (Ack1 !== (2'b01 << expCh)) begin
          errors++;
          $display("FAIL rr_order grant%0d: ack=%b, want %b", n, Ack1, 2'b01 << expCh);
        end
        ch = Ack1[1] ? 1 : 0;
        sb1.push_back(Data1[ch*8 +: 8]);
        Data1[ch*8 +: 8] = 8'(Data1[ch*8 +: 8] + 8'd1);
        n++;
        expCh ^= 1;
      end
    end
    Req1 = 2'b00;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL rr_count: grants=%0d, want 6", n);
    end
    waitIdle(1);
  endtask

  task automatic test_two_stop();
    logic       expSdo, expBusy;
    logic [1:0] expAck;
    @(negedge Clock);
    Data1[7:0] = 8'hFF;
    Req1 = 2'b01;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge Clock);
      expSdo  = !(c >= 2 && c <= 5);
      expBusy = (c >= 1 && c <= 45);
      expAck  = (c == 1) ? 2'b01 : 2'b00;
      checks++;
      if (Sdo1 !== expSdo || Busy1 !== expBusy || Ack1 !== expAck) begin
        errors++;
        $display("FAIL two_stop c%0d: SDO=%b busy=%b ack=%b, want %b %b %b",
                 c, Sdo1, Busy1, Ack1, expSdo, expBusy, expAck);
      end
      if (c == 1) begin
        sb1.push_back(8'hFF);
        Req1 = 2'b00;
      end
    end
    waitIdle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_priority();
    test_fifo_full();
    test_reset_mid();
    test_round_robin();
    test_two_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
